// File: rtl/ram_burst_be.sv
// Single-port burst RAM with per-byte write enables, used as the cache's main-memory model.
// Define RAM_CWF_EN for critical-word-first bursts; otherwise bursts are line-aligned.
module ram_burst_be #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 20,
   parameter int BURST_LEN = 4,
   parameter int LATENCY   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic                  wvalid,
   output logic                  wready,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wbe,
   output logic                  rvalid,
   output logic [DATA_W-1:0]     rdata,
   output logic                  done
);

   localparam int NB     = DATA_W / 8;
   localparam int OFF    = $clog2(BURST_LEN);
   localparam int LINE_W = ADDR_W - OFF;
   localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int DEPTH  = 1 << ADDR_W;

   localparam logic [OFF-1:0]   ONE_BEAT = OFF'(1);
   localparam logic [OFF-1:0]   LAST_BEAT = OFF'(BURST_LEN - 1);
   localparam logic [OFF-1:0]   PEN_BEAT  = OFF'(BURST_LEN - 2);
   localparam logic [CNT_W-1:0] LAT_LOAD  = CNT_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0] LAT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RWAIT  = 2'd1,
      S_RBURST = 2'd2,
      S_WBURST = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [OFF-1:0]      r_beat;
   logic [OFF-1:0]      w_beat_nxt;
   logic [CNT_W-1:0]    r_lat;
   logic [CNT_W-1:0]    w_lat_nxt;
   logic [LINE_W-1:0]   r_line;
   logic [OFF-1:0]      r_start;
   logic [OFF-1:0]      w_start_ld;
   logic                r_req_ready;
   logic                r_wready;
   logic                r_rvalid;
   logic                r_done;
   logic [DATA_W-1:0]   r_rdata;
   logic                w_accept;
   logic                w_done_nxt;
   logic                w_wr_en;
   logic                w_rd_en;
   logic [OFF-1:0]      w_rd_beat;
   logic [ADDR_W-1:0]   w_wr_addr;
   logic [ADDR_W-1:0]   w_rd_addr;
   logic [DATA_W-1:0]   w_wr_word;

   logic [DATA_W-1:0]   r_mem [DEPTH];

   function automatic logic [DATA_W-1:0] merge_bytes(
      input logic [DATA_W-1:0] old_word,
      input logic [DATA_W-1:0] new_word,
      input logic [NB-1:0]     be
   );
      logic [DATA_W-1:0] res;
      res = old_word;
      for (int b = 0; b < NB; b++) begin
         res[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
      end
      return res;
   endfunction

`ifdef RAM_CWF_EN
   assign w_start_ld = req_addr[OFF-1:0];
`else
   logic w_unused_offset;
   assign w_start_ld      = {OFF{1'b0}};
   assign w_unused_offset = ^req_addr[OFF-1:0];
`endif

   assign w_accept  = req_valid & r_req_ready;
   assign w_wr_en   = (r_state == S_WBURST) & wvalid;
   assign w_wr_addr = {r_line, r_start + r_beat};
   // Beat 0 is fetched on the last wait edge; each later beat one edge before it is shown.
   assign w_rd_beat = (r_state == S_RWAIT) ? {OFF{1'b0}} : (r_beat + ONE_BEAT);
   assign w_rd_en   = ((r_state == S_RWAIT) && (r_lat == {CNT_W{1'b0}})) ||
                      ((r_state == S_RBURST) && (r_beat != LAST_BEAT));
   assign w_rd_addr = {r_line, r_start + w_rd_beat};
   assign w_wr_word = merge_bytes(r_mem[w_wr_addr], wdata, wbe);

   // Next-state, beat counter, latency counter and done pulse.
   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat;
      w_lat_nxt   = r_lat;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_beat_nxt = {OFF{1'b0}};
               if (req_we) begin
                  w_state_nxt = S_WBURST;
               end else begin
                  w_state_nxt = S_RWAIT;
                  w_lat_nxt   = LAT_LOAD;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RWAIT: begin
            if (r_lat == {CNT_W{1'b0}}) begin
               w_state_nxt = S_RBURST;
               w_beat_nxt  = {OFF{1'b0}};
            end else begin
               w_lat_nxt = r_lat - LAT_ONE;
            end
         end
         S_RBURST: begin
            if (r_beat == LAST_BEAT) begin
               w_state_nxt = S_IDLE;
               w_beat_nxt  = {OFF{1'b0}};
            end else begin
               w_beat_nxt = r_beat + ONE_BEAT;
               w_done_nxt = (r_beat == PEN_BEAT);
            end
         end
         S_WBURST: begin
            if (wvalid) begin
               if (r_beat == LAST_BEAT) begin
                  w_state_nxt = S_IDLE;
                  w_beat_nxt  = {OFF{1'b0}};
                  w_done_nxt  = 1'b1;
               end else begin
                  w_beat_nxt = r_beat + ONE_BEAT;
               end
            end else begin
               w_beat_nxt = r_beat;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_beat_nxt  = {OFF{1'b0}};
         end
      endcase
   end

   // Control state and registered handshake outputs; reset aborts any burst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_beat      <= {OFF{1'b0}};
         r_lat       <= {CNT_W{1'b0}};
         r_line      <= {LINE_W{1'b0}};
         r_start     <= {OFF{1'b0}};
         r_req_ready <= 1'b0;
         r_wready    <= 1'b0;
         r_rvalid    <= 1'b0;
         r_done      <= 1'b0;
         r_rdata     <= {DATA_W{1'b0}};
      end else begin
         r_state     <= w_state_nxt;
         r_beat      <= w_beat_nxt;
         r_lat       <= w_lat_nxt;
         r_req_ready <= (w_state_nxt == S_IDLE);
         r_wready    <= (w_state_nxt == S_WBURST);
         r_rvalid    <= (w_state_nxt == S_RBURST);
         r_done      <= w_done_nxt;
         if (w_accept) begin
            r_line  <= req_addr[ADDR_W-1:OFF];
            r_start <= w_start_ld;
         end
         if (w_rd_en) begin
            r_rdata <= r_mem[w_rd_addr];
         end
      end
   end

   // Storage array: never reset, so contents survive a mid-burst abort.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[w_wr_addr] <= w_wr_word;
      end
   end

   assign req_ready = r_req_ready;
   assign wready    = r_wready;
   assign rvalid    = r_rvalid;
   assign rdata     = r_rdata;
   assign done      = r_done;

endmodule

// File: tb/tb_ram_burst_be.sv
// Randomised bench for ram_burst_be: per-cycle compare against a word-array model plus literal checks.
// Honours RAM_CWF_EN the same way as the design.
module tb_ram_burst_be;

   localparam int DW  = 32;
   localparam int AW  = 20;
   localparam int BL  = 4;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic          wvalid = 1'b0;
   logic [DW-1:0] wdata = '0;
   logic [3:0]    wbe = '0;
   logic          req_ready;
   logic          wready;
   logic          rvalid;
   logic [DW-1:0] rdata;
   logic          done;

   ram_burst_be #(.DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .wvalid(wvalid), .wready(wready),
      .wdata(wdata), .wbe(wbe), .rvalid(rvalid), .rdata(rdata), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   logic [31:0] mdl [int];
   bit          busy [int];
   bit          wbz  [int];
   bit          erv  [int];
   bit          edn  [int];
   logic [31:0] erd  [int];
   logic [31:0] cap_q [$];
   logic [31:0] wd  [4];
   logic [3:0]  wbm [4];
   int          gp  [4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // word address of beat k for a burst requested at a
   function automatic int baddr(input logic [AW-1:0] a, input int k);
      int ai;
      int st;
      ai = int'(a);
`ifdef RAM_CWF_EN
      st = ai % BL;
`else
      st = 0;
`endif
      return (ai / BL) * BL + (st + k) % BL;
   endfunction

   // per-cycle compare against the expectation tables
   logic e_rr, e_wr, e_rv, e_dn;
   always @(negedge clk) begin
      if (chk_en) begin
         e_rr = (busy.exists(cyc) == 0);
         e_wr = (wbz.exists(cyc) != 0);
         e_rv = (erv.exists(cyc) != 0);
         e_dn = (edn.exists(cyc) != 0);
         chk1("req_ready", req_ready, e_rr);
         chk1("wready", wready, e_wr);
         chk1("rvalid", rvalid, e_rv);
         chk1("done", done, e_dn);
         if (e_rv && (erd.exists(cyc) != 0)) chk("rdata", rdata, erd[cyc]);
         if (rvalid) cap_q.push_back(rdata);
      end
   end

   task automatic release_rst();
      rst = 1'b0;
      req_valid = 1'b0;
      wvalid = 1'b0;
      busy.delete(); wbz.delete(); erv.delete(); erd.delete(); edn.delete();
      @(negedge clk);
      chk1("post_rst_req_ready", req_ready, 1'b1);
      chk1("post_rst_wready", wready, 1'b0);
      chk1("post_rst_rvalid", rvalid, 1'b0);
      chk1("post_rst_done", done, 1'b0);
      chk_en = 1'b1;
   endtask

   task automatic async_reset();
      #2;
      chk_en = 1'b0;
      rst = 1'b1;
      #1;
      chk1("rst_req_ready", req_ready, 1'b0);
      chk1("rst_wready", wready, 1'b0);
      chk1("rst_rvalid", rvalid, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk("rst_rdata", rdata, 32'h0);
      @(negedge clk);
      release_rst();
   endtask

   // called at a negedge; abort>0 resets the DUT that many cycles after acceptance
   task automatic do_read(input logic [AW-1:0] a, input int abort);
      int n;
      n = cyc;
      cap_q.delete();
      req_valid = 1'b1; req_we = 1'b0; req_addr = a; wbe = 4'($urandom);
      for (int k = 1; k <= LAT + BL; k++) busy[n + k] = 1'b1;
      for (int k = 0; k < BL; k++) begin
         erv[n + 1 + LAT + k] = 1'b1;
         if (mdl.exists(baddr(a, k)) != 0) erd[n + 1 + LAT + k] = mdl[baddr(a, k)];
      end
      edn[n + LAT + BL] = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; req_addr = AW'($urandom); req_we = 1'($urandom);
      if (abort > 0) begin
         repeat (abort - 1) @(negedge clk);
         async_reset();
      end else begin
         repeat (LAT + BL) @(negedge clk);
      end
   endtask

   // called at a negedge; beats from wd/wbm with gp idle cycles before each beat
   task automatic do_write(input logic [AW-1:0] a, input int abort, input bit hold);
      int n;
      int ad;
      logic [31:0] w;
      n = cyc;
      req_valid = 1'b1; req_we = 1'b1; req_addr = a;
      busy[n + 1] = 1'b1; wbz[n + 1] = 1'b1;
      @(negedge clk);
      if (!hold) begin
         req_valid = 1'b0; req_addr = AW'($urandom);
      end
      for (int k = 0; k < BL; k++) begin
         for (int g = 0; g < gp[k]; g++) begin
            wvalid = 1'b0; wdata = $urandom; wbe = 4'($urandom);
            busy[cyc + 1] = 1'b1; wbz[cyc + 1] = 1'b1;
            @(negedge clk);
         end
         if (abort > 0 && k == abort) begin
            wvalid = 1'b1; wdata = 32'h77777777; wbe = 4'hF;
            async_reset();
            return;
         end
         wvalid = 1'b1; wdata = wd[k]; wbe = wbm[k];
         ad = baddr(a, k);
         w = (mdl.exists(ad) != 0) ? mdl[ad] : 32'h0;
         for (int b = 0; b < 4; b++) if (wbm[k][b]) w[8*b +: 8] = wd[k][8*b +: 8];
         mdl[ad] = w;
         if (k == BL - 1) begin
            edn[cyc + 1] = 1'b1;
            req_valid = 1'b0;
         end else begin
            busy[cyc + 1] = 1'b1; wbz[cyc + 1] = 1'b1;
         end
         @(negedge clk);
      end
      wvalid = 1'b0; wdata = $urandom; wbe = 4'($urandom);
   endtask

   task automatic chk_cap(input string nm, input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3);
      logic [31:0] e [4];
      e = '{e0, e1, e2, e3};
      chk({nm, "_beats"}, 32'(cap_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < cap_q.size()) chk(nm, cap_q[i], e[i]);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      int lines [6];
      int ln;
      gp = '{0, 0, 0, 0};
      // power-on reset
      @(negedge clk);
      @(negedge clk);
      chk1("init_req_ready", req_ready, 1'b0);
      chk1("init_wready", wready, 1'b0);
      chk1("init_rvalid", rvalid, 1'b0);
      chk1("init_done", done, 1'b0);
      chk("init_rdata", rdata, 32'h0);
      release_rst();

      // full write and readback
      wd  = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      wbm = '{4'hF, 4'hF, 4'hF, 4'hF};
      do_write(20'h00010, 0, 1'b0);
      do_read(20'h00010, 0);
      chk_cap("rd_basic", 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);

      // byte enables, including all-zero beats
      wd  = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hAABBCCDD};
      wbm = '{4'h0, 4'h0, 4'h0, 4'b0101};
      do_write(20'h00010, 0, 1'b0);
      chk("model_be", mdl[32'h13], 32'h44BB44DD);
      do_read(20'h00010, 0);
      chk_cap("rd_be", 32'h11111111, 32'h22222222, 32'h33333333, 32'h44BB44DD);

      // offset within the line
      do_read(20'h00012, 0);
`ifdef RAM_CWF_EN
      chk_cap("rd_wrap", 32'h33333333, 32'h44BB44DD, 32'h11111111, 32'h22222222);
`else
      chk_cap("rd_wrap", 32'h11111111, 32'h22222222, 32'h33333333, 32'h44BB44DD);
`endif

      // wvalid gap with the request held
      wd  = '{32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3, 32'hA4A4A4A4};
      wbm = '{4'hF, 4'hF, 4'hF, 4'hF};
      gp  = '{0, 0, 2, 0};
      do_write(20'h00020, 0, 1'b1);
      gp  = '{0, 0, 0, 0};
      do_read(20'h00020, 0);
      chk_cap("rd_gap", 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3, 32'hA4A4A4A4);

      // reset after two write beats
      wd = '{32'h55555555, 32'h66666666, 32'h88888888, 32'h99999999};
      do_write(20'h00010, 2, 1'b0);
      do_read(20'h00010, 0);
      chk_cap("rd_abort", 32'h55555555, 32'h66666666, 32'h33333333, 32'h44BB44DD);

      // reset in the middle of a read burst
      do_read(20'h00010, 4);

      // randomised traffic over a small pool of pre-filled lines
      for (int i = 0; i < 6; i++) begin
         lines[i] = 1000 + i * 4093;
         for (int k = 0; k < 4; k++) begin
            wd[k] = $urandom; wbm[k] = 4'hF; gp[k] = $urandom_range(0, 1);
         end
         do_write(AW'(lines[i] * 4 + $urandom_range(0, 3)), 0, 1'b0);
      end
      repeat (40) begin
         ln = lines[$urandom_range(0, 5)];
         if ($urandom_range(0, 1) == 1) begin
            for (int k = 0; k < 4; k++) begin
               wd[k] = $urandom; wbm[k] = 4'($urandom); gp[k] = $urandom_range(0, 2);
            end
            do_write(AW'(ln * 4 + $urandom_range(0, 3)), 0, 1'($urandom));
         end else begin
            do_read(AW'(ln * 4 + $urandom_range(0, 3)), 0);
         end
      end
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
